fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch sequencer.
// Reads an opcode byte at i_pc and, depending on the decoded length, up to
// two operand bytes. The assembled bundle is presented on o_opcode/o_operand
// with o_valid until the execute stage consumes it.
// Build option: define FETCH_WAIT_EN to honour i_ready for memory wait
// states. When it is undefined every read completes in a single cycle and
// i_ready is ignored, although the port is still present.
module fetch_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_pc,
    output logic        o_pc_inc,
    output logic [15:0] o_addr,
    output logic        o_rd_en,
    input  logic [7:0]  i_data,
    input  logic        i_ready,
    input  logic [1:0]  i_len,
    output logic [7:0]  o_opcode,
    output logic [15:0] o_operand,
    output logic        o_valid,
    output logic        o_illegal,
    input  logic        i_consume,
    input  logic        i_flush
);

    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  opcode_q;
    logic [15:0] operand_q;
    logic        three_byte_q;   // bundle needs a high operand byte
    logic        valid_q;
    logic        illegal_q;

    logic        ready_eff;
    logic        rd_done;

`ifdef FETCH_WAIT_EN
    assign ready_eff = i_ready;
`else
    // Memory is assumed zero-wait; i_ready is deliberately left unused.
    logic unused_ready;
    assign unused_ready = i_ready;
    assign ready_eff    = 1'b1;
`endif

    // The address always follows the PC; pc_control advances it on o_pc_inc.
    assign o_addr   = i_pc;
    // A read is outstanding in every fetch state; reset masks it immediately.
    assign o_rd_en  = i_rst_n && (state_q != HOLD);
    assign rd_done  = o_rd_en && ready_eff;
    // Increment only for a read that actually lands; a flush throws it away.
    assign o_pc_inc = rd_done && !i_flush;

    assign o_opcode  = opcode_q;
    assign o_operand = operand_q;
    assign o_valid   = valid_q;
    assign o_illegal = illegal_q;

    // Fetch sequencer: state, bundle latches and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= FETCH_OP;
            opcode_q     <= 8'h00;
            operand_q    <= 16'h0000;
            three_byte_q <= 1'b0;
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (i_flush) begin
            // Redirect: drop whatever was in flight, latches untouched.
            state_q <= FETCH_OP;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (rd_done) begin
                        opcode_q     <= i_data;
                        operand_q    <= 16'h0000;
                        three_byte_q <= (i_len == 2'd3);
                        // Length 0 is undefined; run it as a one-byte bundle.
                        illegal_q    <= (i_len == 2'd0);
                        if (i_len[1]) begin
                            state_q <= FETCH_LO;
                        end else begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                FETCH_LO: begin
                    if (rd_done) begin
                        operand_q[7:0] <= i_data;
                        if (three_byte_q) begin
                            state_q <= FETCH_HI;
                        end else begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                FETCH_HI: begin
                    if (rd_done) begin
                        operand_q[15:8] <= i_data;
                        state_q         <= HOLD;
                        valid_q         <= 1'b1;
                    end
                end
                HOLD: begin
                    if (i_consume) begin
                        state_q <= FETCH_OP;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FETCH_OP;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
